// File: rtl/fwd_scoreboard.sv
// Operand-forwarding unit: tracks in-flight producers in a shift register and
// serves read ports from the youngest matching stage, stalling on unready results.
module fwd_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int REG_W    = 3,
  parameter int DEPTH    = 6,
  parameter int NUM_RD   = 2,
  parameter int LAT_W    = 3,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     adv_in,
  input  logic                     flush_in,
  input  logic                     iss_valid_in,
  input  logic                     iss_wr_in,
  input  logic [REG_W-1:0]         iss_reg_in,
  input  logic [LAT_W-1:0]         iss_lat_in,
  input  logic [DEPTH*DATA_W-1:0]  stage_data_in,
  input  logic [NUM_RD*REG_W-1:0]  rd_reg_in,
  input  logic [NUM_RD*DATA_W-1:0] rf_data_in,
  output logic [NUM_RD*DATA_W-1:0] rd_data_out,
  output logic [NUM_RD-1:0]        rd_hit_out,
  output logic                     stall_out,
  output logic [15:0]              stall_cnt_out
);

  // Index 0 holds stage 1 (the most recently issued instruction).
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] wr_reg;
  logic [REG_W-1:0] reg_reg [DEPTH];
  logic [LAT_W-1:0] lat_reg [DEPTH];
  logic [15:0]      stall_cnt_reg;

  logic [NUM_RD-1:0] unavail;
  logic              stall;
  logic [LAT_W-1:0]  iss_lat_norm;

  assign iss_lat_norm = (iss_lat_in == '0) ? LAT_W'(1) : iss_lat_in;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_port
      logic [REG_W-1:0]  src;
      logic [DATA_W-1:0] rf;
      logic              found;
      logic [LAT_W-1:0]  win_stage;
      logic [LAT_W-1:0]  win_lat;
      logic [DATA_W-1:0] win_data;
      logic              is_zero;
      logic [DATA_W-1:0] data;
      logic              hit;
      logic              unav;

      assign src     = rd_reg_in[gi*REG_W +: REG_W];
      assign rf      = rf_data_in[gi*DATA_W +: DATA_W];
      assign is_zero = (ZERO_REG != 0) && (src == '0);

      // Scan oldest to youngest so the youngest live match overwrites the rest.
      always_comb begin
        found     = 1'b0;
        win_stage = '0;
        win_lat   = '0;
        win_data  = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
          if (valid_reg[s] && wr_reg[s] && (reg_reg[s] == src)) begin
            found     = 1'b1;
            win_stage = LAT_W'(s + 1);
            win_lat   = lat_reg[s];
            win_data  = stage_data_in[s*DATA_W +: DATA_W];
          end
        end
      end

      always_comb begin
        data = rf;
        hit  = 1'b0;
        unav = 1'b0;
        if (is_zero) begin
          data = '0;
        end else if (found) begin
          if (win_stage >= win_lat) begin
            data = win_data;
            hit  = 1'b1;
          end else begin
            unav = 1'b1;
          end
        end
      end

      assign rd_data_out[gi*DATA_W +: DATA_W] = data;
      assign rd_hit_out[gi]                   = hit;
      assign unavail[gi]                      = unav;
    end
  endgenerate

  assign stall         = iss_valid_in && (|unavail);
  assign stall_out     = stall;
  assign stall_cnt_out = stall_cnt_reg;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_reg     <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (adv_in && stall && !flush_in && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
      if (flush_in) begin
        valid_reg <= '0;
      end else if (adv_in) begin
        for (int s = DEPTH - 1; s >= 1; s--) begin
          valid_reg[s] <= valid_reg[s-1];
          wr_reg[s]    <= wr_reg[s-1];
          reg_reg[s]   <= reg_reg[s-1];
          lat_reg[s]   <= lat_reg[s-1];
        end
        // A stalled or absent issue enters the pipe as a bubble.
        valid_reg[0] <= iss_valid_in && !stall;
        wr_reg[0]    <= iss_wr_in;
        reg_reg[0]   <= iss_reg_in;
        lat_reg[0]   <= iss_lat_norm;
      end
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed load-use/flush/zero-reg steps
// plus random traffic checked against a queue-based model of in-flight producers.
module tb_fwd_scoreboard;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int DEPTH  = 6;
  localparam int NUM_RD = 2;
  localparam int LAT_W  = 3;

  logic clk = 1'b0;
  logic rst, adv, flush, iss_valid, iss_wr;
  logic [REG_W-1:0]         iss_reg;
  logic [LAT_W-1:0]         iss_lat;
  logic [DEPTH*DATA_W-1:0]  stage_data;
  logic [NUM_RD*REG_W-1:0]  rd_reg;
  logic [NUM_RD*DATA_W-1:0] rf_data;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_hit;
  logic                     stall;
  logic [15:0]              stall_cnt;

  always #5 clk = ~clk;

  fwd_scoreboard #(
    .DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH),
    .NUM_RD(NUM_RD), .LAT_W(LAT_W), .ZERO_REG(1)
  ) dut (
    .clk_in(clk), .rst_in(rst), .adv_in(adv), .flush_in(flush),
    .iss_valid_in(iss_valid), .iss_wr_in(iss_wr), .iss_reg_in(iss_reg),
    .iss_lat_in(iss_lat), .stage_data_in(stage_data), .rd_reg_in(rd_reg),
    .rf_data_in(rf_data), .rd_data_out(rd_data), .rd_hit_out(rd_hit),
    .stall_out(stall), .stall_cnt_out(stall_cnt)
  );

  // Model: trk[0] is the youngest in-flight instruction (stage 1).
  typedef struct { bit v; bit wr; int r; int lat; } ent_t;
  ent_t trk [$];
  int   model_cnt;
  int   n_checks;
  int   n_fail;
  bit   do_check;
  bit   exp_stall;
  int   n_stall;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_port(int p, output logic [15:0] data, output bit hit, output bit unav);
    int r;
    int lat;
    r    = int'(rd_reg[p*REG_W +: REG_W]);
    data = rf_data[p*DATA_W +: DATA_W];
    hit  = 1'b0;
    unav = 1'b0;
    if (r == 0) begin
      data = '0;
      return;
    end
    for (int s = 0; s < trk.size(); s++) begin
      if (trk[s].v && trk[s].wr && trk[s].r == r) begin
        lat = (trk[s].lat == 0) ? 1 : trk[s].lat;
        if (s + 1 >= lat) begin
          data = stage_data[s*DATA_W +: DATA_W];
          hit  = 1'b1;
        end else begin
          unav = 1'b1;
        end
        return;
      end
    end
  endfunction

  task automatic model_clear();
    foreach (trk[i]) trk[i].v = 1'b0;
  endtask

  // Let inputs settle, compare all outputs against the model.
  task automatic settle();
    logic [15:0] d;
    bit h, u, any_u;
    any_u = 1'b0;
    #4;
    for (int p = 0; p < NUM_RD; p++) begin
      model_port(p, d, h, u);
      any_u |= u;
      if (do_check) begin
        if (!u) check($sformatf("rd_data%0d", p), 32'(rd_data[p*DATA_W +: DATA_W]), 32'(d));
        check($sformatf("rd_hit%0d", p), 32'(rd_hit[p]), 32'(h));
      end
    end
    exp_stall = iss_valid && any_u;
    if (do_check) begin
      check("stall", 32'(stall), 32'(exp_stall));
      check("stall_cnt", 32'(stall_cnt), 32'(model_cnt));
    end
  endtask

  task automatic clk_step();
    ent_t e;
    @(posedge clk);
    if (rst) begin
      model_clear();
      model_cnt = 0;
    end else begin
      if (adv && exp_stall && !flush) begin
        n_stall++;
        if (model_cnt < 65535) model_cnt++;
      end
      if (flush) begin
        model_clear();
      end else if (adv) begin
        e.v = iss_valid && !exp_stall; e.wr = iss_wr; e.r = int'(iss_reg); e.lat = int'(iss_lat);
        trk.push_front(e);
        void'(trk.pop_back());
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    clk_step();
  endtask

  task automatic set_rd(int p, int r, logic [15:0] rf);
    rd_reg[p*REG_W +: REG_W]   = REG_W'(r);
    rf_data[p*DATA_W +: DATA_W] = rf;
  endtask

  task automatic set_iss(bit v, bit wr, int r, int lat, bit a);
    iss_valid = v; iss_wr = wr; iss_reg = REG_W'(r); iss_lat = LAT_W'(lat); adv = a;
  endtask

  task automatic set_stage(int s, logic [15:0] d);
    stage_data[(s-1)*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    ent_t e0;
    n_checks = 0; n_fail = 0; model_cnt = 0; n_stall = 0;
    e0.v = 1'b0; e0.wr = 1'b0; e0.r = 0; e0.lat = 1;
    for (int i = 0; i < DEPTH; i++) trk.push_back(e0);
    rst = 1'b1; flush = 1'b0; stage_data = '0; rd_reg = '0; rf_data = '0;
    set_iss(0, 0, 0, 0, 0);
    do_check = 1'b0;
    @(posedge clk); #1;
    cyc(); cyc();
    rst = 1'b0; do_check = 1'b1;

    // Reset state: plain register-file read.
    set_rd(0, 3, 16'h1111); set_rd(1, 0, 16'h9999);
    settle();
    check("tp_reset_data", 32'(rd_data[15:0]), 32'h1111);
    check("tp_reset_hit", 32'(rd_hit), 32'h0);
    check("tp_reset_stall", 32'(stall), 32'h0);
    check("tp_reset_cnt", 32'(stall_cnt), 32'h0);
    clk_step();

    // Forward r3 from stage 1, then from stage 3.
    set_iss(1, 1, 3, 1, 1); cyc();
    set_iss(0, 0, 0, 0, 0); set_stage(1, 16'hAAAA);
    settle();
    check("tp_fwd_s1", 32'(rd_data[15:0]), 32'hAAAA);
    check("tp_fwd_s1_hit", 32'(rd_hit[0]), 32'h1);
    clk_step();
    adv = 1'b1; cyc(); cyc();
    adv = 1'b0; set_stage(3, 16'hAAAA); set_stage(1, 16'h0BAD);
    settle();
    check("tp_fwd_s3", 32'(rd_data[15:0]), 32'hAAAA);
    clk_step();

    // Youngest producer wins.
    set_rd(0, 0, 16'h1234);
    set_iss(1, 1, 2, 1, 1); cyc();
    set_iss(1, 1, 2, 1, 1); cyc();
    set_iss(0, 0, 0, 0, 0);
    set_stage(1, 16'h3333); set_stage(2, 16'h2222); set_rd(0, 2, 16'h1234);
    settle();
    check("tp_youngest", 32'(rd_data[15:0]), 32'h3333);
    clk_step();

    // Load-use: r5 with latency 3 stalls a consumer for two advancing cycles.
    set_rd(0, 0, 16'h0);
    set_iss(1, 1, 5, 3, 1); cyc();
    set_rd(0, 5, 16'hDEAD); set_iss(1, 1, 6, 1, 1);
    settle(); check("tp_lu_stall1", 32'(stall), 32'h1); clk_step();
    settle(); check("tp_lu_stall2", 32'(stall), 32'h1); clk_step();
    set_stage(3, 16'h5555);
    settle();
    check("tp_lu_release", 32'(stall), 32'h0);
    check("tp_lu_data", 32'(rd_data[15:0]), 32'h5555);
    check("tp_lu_cnt", 32'(stall_cnt), 32'h2);
    clk_step();

    // Flush with advance: nothing survives, nothing inserted.
    set_rd(0, 0, 16'h0);
    set_iss(1, 1, 4, 1, 1); cyc();
    flush = 1'b1; set_iss(1, 1, 7, 1, 1); cyc();
    flush = 1'b0; set_iss(0, 0, 0, 0, 0);
    for (int s = 1; s <= DEPTH; s++) set_stage(s, 16'hF000 | 16'(s));
    set_rd(0, 4, 16'h4444); set_rd(1, 7, 16'h7777);
    settle();
    check("tp_flush_r4", 32'(rd_data[15:0]), 32'h4444);
    check("tp_flush_r7", 32'(rd_data[31:16]), 32'h7777);
    check("tp_flush_hit", 32'(rd_hit), 32'h0);
    clk_step();

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 15) == 0);
      set_iss($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3) != 0);
      for (int s = 1; s <= DEPTH; s++) set_stage(s, 16'($urandom));
      for (int p = 0; p < NUM_RD; p++) set_rd(p, $urandom_range(0, 7), 16'($urandom));
      cyc();
    end
    rst = 1'b0; flush = 1'b0;

    // Register 0 is never forwarded nor stalls.
    set_rd(0, 0, 16'h0); set_rd(1, 0, 16'h0);
    set_iss(1, 1, 0, 1, 1); cyc();
    set_rd(0, 0, 16'hFFFF); set_iss(1, 0, 1, 1, 0);
    settle();
    check("tp_zero_data", 32'(rd_data[15:0]), 32'h0);
    check("tp_zero_hit", 32'(rd_hit[0]), 32'h0);
    check("tp_zero_stall", 32'(stall), 32'h0);
    clk_step();

    // Saturate the stall counter with never-forwardable producers.
    rst = 1'b1; cyc(); rst = 1'b0;
    n_stall = 0; do_check = 1'b0;
    while (n_stall < 65540) begin
      set_rd(0, 0, 16'h0); set_iss(1, 1, 5, 7, 1); cyc();
      set_rd(0, 5, 16'h0);
      for (int k = 0; k < DEPTH; k++) cyc();
    end
    do_check = 1'b1;
    set_iss(0, 0, 0, 0, 0);
    settle();
    check("tp_sat_cnt", 32'(stall_cnt), 32'hFFFF);
    clk_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised operand-forwarding unit with an internal in-flight producer tracker.
- Records each issued instruction's destination register, write enable and result latency in a DEPTH-stage shift register that advances with the pipeline.
- Serves NUM_RD read ports from the youngest matching in-flight result, or from the register file when nothing matches.
- Raises a stall when the youngest matching producer's result does not exist yet (load-use hazard). Sits between decode/register-read and issue.

Parameters:
DATA_W, 16, operand/result width
REG_W, 3, register-number width
DEPTH, 6, number of tracked in-flight stages (stage 1 = most recently issued)
NUM_RD, 2, number of read ports
LAT_W, 3, width of the latency field; must satisfy DEPTH < 2**LAT_W
ZERO_REG, 0, 1 = register 0 is hardwired zero: never forwarded, reads 0, never stalls

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous reset, active-high
adv_in  input  1  pipeline advances this cycle
flush_in  input  1  kill all tracked producers
iss_valid_in  input  1  decode instruction requests issue
iss_wr_in  input  1  issuing instruction writes a register
iss_reg_in  input  REG_W  destination register of issuing instruction
iss_lat_in  input  LAT_W  first stage (1..DEPTH) at which its result is on stage_data_in
stage_data_in  input  DEPTH*DATA_W  result held in stage s, at slice s-1
rd_reg_in  input  NUM_RD*REG_W  source register per read port
rf_data_in  input  NUM_RD*DATA_W  register-file read data per port
rd_data_out  output  NUM_RD*DATA_W  forwarded operand per port
rd_hit_out  output  NUM_RD  port p was served from an in-flight stage
stall_out  output  1  issue blocked by an unavailable operand
stall_cnt_out  output  16  saturating count of cycles with adv_in && stall_out

Behaviour:
- Entry state for s = 1..DEPTH: valid, wr, reg, lat. Entry s is live when valid && wr.
- Reset (rst_in=1 at a clock edge):
  - All entries become invalid; stall_cnt_out becomes 0.
  - Combinational outputs therefore read: stall_out=0, rd_hit_out=0, rd_data_out=rf_data_in (0 for register 0 when ZERO_REG=1).
  - Reset overrides adv_in and flush_in.
- Match rule: port p matches entry s when the entry is live and reg == rd_reg_p. The winning match is the lowest s (youngest). Older matches are ignored, even when available.
- Port output is combinational, zero latency:
  - Winning match s with s >= lat: rd_data_p = stage_data_in slice s-1, hit_p = 1.
  - Winning match s with s < lat: port unavailable, hit_p = 0, rd_data_p = rf_data_p (don't-care while stalled).
  - No match: rd_data_p = rf_data_p, hit_p = 0.
  - ZERO_REG=1 and rd_reg_p = 0: rd_data_p = 0, hit_p = 0, port never unavailable.
- stall_out = iss_valid_in && (any port unavailable). Ports are always evaluated; the decode stage masks unused ports by pointing them at register 0 or a free register.
- Clock-edge update, first matching rule applies:
  - rst_in: reset as above.
  - flush_in: all entries invalid, no insertion. Flush wins over adv_in; stall_cnt_out unchanged.
  - adv_in=0: entries hold.
  - adv_in=1: entry s+1 takes entry s; the entry at DEPTH is dropped. Entry 1 is loaded as follows:
    - iss_valid_in && !stall_out: {valid=1, wr=iss_wr_in, reg=iss_reg_in, lat=iss_lat_in}.
    - Otherwise: a bubble (valid=0).
- stall_cnt_out increments when adv_in && stall_out && !flush_in, saturating at 0xFFFF with no wrap.
- iss_lat_in of 0 is treated as 1. iss_lat_in > DEPTH means the result is never forwardable: a matching port stalls until that entry leaves the tracker.
- Stage slices whose entry is not live are ignored.

Test Plan:
- Reset, then read r3 with rf_data=0x1111 and no issues -> rd_data=0x1111, hit=0, stall_out=0, stall_cnt_out=0.
- Issue r3 with lat=1, advance 1; stage1 data=0xAAAA; read r3 -> 0xAAAA, hit=1. Advance 2 more with bubbles, stage3=0xAAAA -> still 0xAAAA from stage 3.
- Issue r2 lat=1 with 0x2222, then r2 lat=1 with 0x3333, advance; read r2 -> 0x3333 from stage 1 (youngest wins over stage 2).
- Load-use: issue r5 lat=3, advance; issue reading r5 -> stall_out=1 for 2 advancing cycles (bubbles inserted, stall_cnt_out=2). At stage 3 with data 0x5555 -> stall_out=0, rd_data=0x5555.
- Flush with r4 in flight and adv_in=1 in the same cycle -> next cycle read r4 returns rf_data, no hit; no insertion occurred.
- ZERO_REG=1: issue r0 lat=1, read r0 -> 0, hit=0, no stall. Force 65540 stall cycles -> stall_cnt_out=0xFFFF.
